// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_pkg
// Description : Shared types, sizes and one-hot helpers for the round-robin
//               arbiter and its request/service front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of set bits; wide enough to hold N_REQ itself.
    function automatic logic [IDX_W:0] popcount(input logic [N_REQ-1:0] vec);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [N_REQ-1:0] vec);
        return (popcount(vec) == (IDX_W + 1)'(1));
    endfunction

    // Index of the set bit; only meaningful when the input is one-hot.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_service_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : req_service_ctrl_if
// Description : Request/grant/status bundle between the requesters, the
//               arbiter and the request service controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface req_service_ctrl_if #(
    parameter int N_REQ = rr_pkg::N_REQ,
    parameter int IDX_W = rr_pkg::IDX_W
);
    logic [N_REQ-1:0] req_pulse_i;
    logic [N_REQ-1:0] grant_i;
    logic             any_grant_i;
    logic [N_REQ-1:0] reqs_o;
    logic             grant_en_o;
    logic             busy_o;
    logic [IDX_W-1:0] serving_o;
    logic [N_REQ-1:0] ack_o;
    logic [IDX_W:0]   pend_cnt_o;
    logic             dup_o;
    logic             err_o;

    // Controller side
    modport slave (
        input  req_pulse_i, grant_i, any_grant_i,
        output reqs_o, grant_en_o, busy_o, serving_o, ack_o,
               pend_cnt_o, dup_o, err_o
    );

    // Requester/arbiter side
    modport master (
        output req_pulse_i, grant_i, any_grant_i,
        input  reqs_o, grant_en_o, busy_o, serving_o, ack_o,
               pend_cnt_o, dup_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/svc_timer.sv
`default_nettype none
// ============================================================================
// Module      : svc_timer
// Description : Loadable down-counter that parks at zero; zero_o flags the
//               last cycle of a service window.
// Revision    : 1.0 - initial release
// ============================================================================
module svc_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    input  wire logic             dec_i,
    output logic                  zero_o
);
    logic [WIDTH-1:0] r_cnt;

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (dec_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign zero_o = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/req_service_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : req_service_ctrl
// Description : Latches request pulses into a pending vector for the
//               arbiter, accepts one one-hot grant at a time, serves it for
//               SVC_CYCLES cycles, then acks and retires the request.
// Revision    : 1.0 - initial release
// ============================================================================
module req_service_ctrl
    import rr_pkg::state_t, rr_pkg::IDLE, rr_pkg::SERVE, rr_pkg::DONE,
           rr_pkg::IDX_W, rr_pkg::popcount, rr_pkg::is_onehot,
           rr_pkg::onehot_to_idx;
#(
    parameter int N_REQ      = rr_pkg::N_REQ,
    parameter int SVC_CYCLES = 4            // legal range 1..15
) (
    input  wire logic         clk,
    input  wire logic         rst,
    req_service_ctrl_if.slave bus
);
    // Timer starts one below the window length because the zero cycle is
    // itself the last SERVE cycle.
    localparam logic [3:0] c_timer_load = 4'(SVC_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] r_pend;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] w_clr;
    logic [IDX_W-1:0] r_serving;
    logic             r_busy;
    logic             r_dup;
    logic             r_err;
    logic             w_grant_ok;
    logic             w_timer_load;
    logic             w_timer_dec;
    logic             w_timer_zero;
    logic             w_err_set;

    svc_timer #(
        .WIDTH (4)
    ) u_svc_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_timer_load),
        .load_val_i (c_timer_load),
        .dec_i      (w_timer_dec),
        .zero_o     (w_timer_zero)
    );

    // Grant acceptance; gated by reset so the arbiter never advances then.
    always_comb begin
        w_grant_ok = rst && (r_state == IDLE) && bus.any_grant_i
                     && is_onehot(bus.grant_i);
    end

    // Next-state logic and timer/flag strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.any_grant_i) begin
                    if (is_onehot(bus.grant_i)) begin
                        w_state_nxt  = SERVE;
                        w_timer_load = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (w_timer_zero) begin
                    w_state_nxt = DONE;
                end else begin
                    w_timer_dec = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The served bit retires only in DONE.
    always_comb begin
        w_clr = (r_state == DONE) ? (N_REQ'(1) << r_serving) : '0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_ack     <= '0;
            r_serving <= '0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_ack  <= (w_state_nxt == DONE) ? (N_REQ'(1) << r_serving) : '0;
            if (w_timer_load) begin
                r_serving <= onehot_to_idx(bus.grant_i);
            end
        end
    end

    // Pending vector: a new pulse wins over a same-cycle retire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | bus.req_pulse_i;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dup <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (|(bus.req_pulse_i & r_pend & ~w_clr)) begin
                r_dup <= 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.reqs_o     = r_pend;
    assign bus.grant_en_o = w_grant_ok;
    assign bus.busy_o     = r_busy;
    assign bus.serving_o  = r_serving;
    assign bus.ack_o      = r_ack;
    assign bus.pend_cnt_o = popcount(r_pend);
    assign bus.dup_o      = r_dup;
    assign bus.err_o      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_req_service_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_service_ctrl
// Description : Directed and random checks of req_service_ctrl against a
//               timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_service_ctrl;
    localparam int SVC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    req_service_ctrl_if bus ();

    req_service_ctrl #(
        .N_REQ      (8),
        .SVC_CYCLES (SVC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: pending set plus the cycle number of the next ack.
    logic [7:0] m_pend = '0;
    logic [2:0] m_srv  = '0;
    logic       m_dup  = 1'b0;
    logic       m_err  = 1'b0;
    int         m_done = -1;

    // Values observed at the most recent mid-cycle sample point.
    logic [7:0] s_reqs, s_ack;
    logic [3:0] s_cnt;
    logic [2:0] s_srv;
    logic       s_gen, s_busy, s_dup, s_err;

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [2:0] bit_pos(input logic [7:0] v);
        logic [2:0] p = '0;
        for (int i = 0; i < 8; i++) if (v[i]) p = 3'(i);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: sample and compare at negedge, advance model at posedge.
    task automatic cycle();
        logic       e_busy;
        logic [7:0] e_ack;
        logic       e_gen;
        @(negedge clk);
        e_busy = (m_done >= 0) && (cyc <= m_done);
        e_ack  = (m_done >= 0 && cyc == m_done) ? (8'd1 << m_srv) : 8'd0;
        e_gen  = rst && !e_busy && bus.any_grant_i && (ones(bus.grant_i) == 1);
        s_reqs = bus.reqs_o;     s_ack  = bus.ack_o;    s_cnt = bus.pend_cnt_o;
        s_srv  = bus.serving_o;  s_gen  = bus.grant_en_o;
        s_busy = bus.busy_o;     s_dup  = bus.dup_o;    s_err = bus.err_o;
        chk("reqs",     s_reqs, m_pend);
        chk("pend_cnt", s_cnt,  ones(m_pend));
        chk("grant_en", s_gen,  e_gen);
        chk("busy",     s_busy, e_busy);
        chk("ack",      s_ack,  e_ack);
        chk("serving",  s_srv,  m_srv);
        chk("dup",      s_dup,  m_dup);
        chk("err",      s_err,  m_err);
        @(posedge clk);
        if (!rst) begin
            m_pend = '0; m_srv = '0; m_dup = 1'b0; m_err = 1'b0; m_done = -1;
        end else begin
            if (|(bus.req_pulse_i & m_pend & ~e_ack)) m_dup = 1'b1;
            m_pend = (m_pend & ~e_ack) | bus.req_pulse_i;
            if (!e_busy && bus.any_grant_i) begin
                if (ones(bus.grant_i) == 1) begin
                    m_srv  = bit_pos(bus.grant_i);
                    m_done = cyc + SVC + 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        cyc++;
        #1;
    endtask

    // Run until an ack is seen, bounded.
    task automatic wait_ack(input string tag, input logic [7:0] exp);
        logic found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            cycle();
            if (s_ack != 8'd0) found = 1'b1;
        end
        chk({tag, "_seen"}, found, 1'b1);
        chk({tag, "_val"},  s_ack, exp);
    endtask

    logic [7:0] g_list [3] = '{8'h01, 8'h10, 8'h80};
    logic [7:0] acc;
    int         last_ack;
    int         r;

    initial begin
        // Reset with every input active.
        bus.req_pulse_i = 8'hFF; bus.grant_i = 8'h01; bus.any_grant_i = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        cycle();
        cycle();
        chk("rst_reqs", s_reqs, 8'h00);  chk("rst_cnt", s_cnt, 4'd0);
        chk("rst_gen",  s_gen,  1'b0);   chk("rst_busy", s_busy, 1'b0);
        chk("rst_ack",  s_ack,  8'h00);  chk("rst_srv", s_srv, 3'd0);
        chk("rst_dup",  s_dup,  1'b0);   chk("rst_err", s_err, 1'b0);
        rst = 1'b1; bus.req_pulse_i = '0; bus.grant_i = '0; bus.any_grant_i = 1'b0;
        cycle();

        // Single request on bit 5.
        bus.req_pulse_i = 8'h20; cycle();
        bus.req_pulse_i = '0; bus.grant_i = 8'h20; bus.any_grant_i = 1'b1; cycle();
        chk("single_gen",  s_gen,  1'b1);
        chk("single_reqs", s_reqs, 8'h20);
        bus.any_grant_i = 1'b0; bus.grant_i = '0;
        for (int k = 0; k < SVC; k++) begin
            cycle();
            chk("single_busy", s_busy, 1'b1);
            chk("single_srv",  s_srv,  3'd5);
        end
        cycle();
        chk("single_ack", s_ack, 8'h20);
        cycle();
        chk("single_clr", s_reqs, 8'h00);
        chk("single_idle", s_busy, 1'b0);

        // Three pending requests served back to back.
        bus.req_pulse_i = 8'h91; cycle();
        bus.req_pulse_i = '0; cycle();
        chk("multi_cnt0", s_cnt, 4'd3);
        last_ack = 0;
        for (int k = 0; k < 3; k++) begin
            bus.grant_i = g_list[k]; bus.any_grant_i = 1'b1; cycle();
            chk("multi_cnt", s_cnt, 3 - k);
            chk("multi_gen", s_gen, 1'b1);
            bus.grant_i = '0; bus.any_grant_i = 1'b0;
            wait_ack("multi_ack", g_list[k]);
            if (k > 0) chk("multi_spacing", cyc - last_ack, SVC + 2);
            last_ack = cyc;
        end
        cycle();
        chk("multi_cnt_end", s_cnt, 4'd0);

        // Duplicate pulse, then a pulse that collides with the retire.
        rst = 1'b0; cycle(); cycle(); rst = 1'b1;
        bus.req_pulse_i = 8'h04; cycle(); cycle();
        bus.req_pulse_i = '0; cycle();
        chk("dup_flag", s_dup, 1'b1);
        chk("dup_cnt",  s_cnt, 4'd1);
        bus.grant_i = 8'h04; bus.any_grant_i = 1'b1; cycle();
        bus.grant_i = '0; bus.any_grant_i = 1'b0;
        for (int k = 0; k < SVC; k++) cycle();
        bus.req_pulse_i = 8'h04; cycle();
        chk("setwin_ack", s_ack, 8'h04);
        bus.req_pulse_i = '0; cycle();
        chk("setwin_reqs", s_reqs, 8'h04);

        // Bad grant, then grant changes during SERVE.
        bus.grant_i = 8'h06; bus.any_grant_i = 1'b1; cycle();
        chk("bad_gen", s_gen, 1'b0);
        bus.any_grant_i = 1'b0; cycle();
        chk("bad_err",  s_err,  1'b1);
        chk("bad_idle", s_busy, 1'b0);
        bus.grant_i = 8'h04; bus.any_grant_i = 1'b1; cycle();
        bus.grant_i = 8'h01; cycle(); cycle();
        chk("ignore_srv", s_srv, 3'd2);
        chk("ignore_gen", s_gen, 1'b0);
        bus.grant_i = '0; bus.any_grant_i = 1'b0;
        wait_ack("ignore_ack", 8'h04);

        // Reset in the second SERVE cycle drops the service.
        bus.req_pulse_i = 8'h08; cycle();
        bus.req_pulse_i = '0; bus.grant_i = 8'h08; bus.any_grant_i = 1'b1; cycle();
        bus.grant_i = '0; bus.any_grant_i = 1'b0; cycle();
        rst = 1'b0; cycle();
        chk("midrst_busy", s_busy, 1'b1);
        rst = 1'b1;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            acc = acc | s_ack;
        end
        chk("midrst_noack", acc, 8'h00);
        chk("midrst_reqs",  s_reqs, 8'h00);
        bus.req_pulse_i = 8'h40; cycle();
        bus.req_pulse_i = '0; bus.grant_i = 8'h40; bus.any_grant_i = 1'b1; cycle();
        bus.grant_i = '0; bus.any_grant_i = 1'b0;
        wait_ack("resume_ack", 8'h40);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      bus.req_pulse_i = 8'($urandom);
            else if (r < 3)  bus.req_pulse_i = 8'd1 << $urandom_range(0, 7);
            else             bus.req_pulse_i = '0;
            bus.any_grant_i = ($urandom_range(0, 2) == 0);
            if (m_pend != 8'd0 && $urandom_range(0, 7) != 0) begin
                r = int'($urandom_range(0, 7));
                while (!m_pend[r[2:0]]) r = (r + 1) % 8;
                bus.grant_i = 8'd1 << r;
            end else begin
                bus.grant_i = 8'($urandom);
            end
            rst = ($urandom_range(0, 96) != 0);
            cycle();
        end
        rst = 1'b1; bus.req_pulse_i = '0; bus.any_grant_i = 1'b0; bus.grant_i = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
